// File: rtl/datas_dist_cm.sv
// Frame distributor: reads a header+payload+checksum frame from the CDDB and
// copies the payload into one of six channel TX RAMs, committing the length last.
module datas_dist_cm #(
  parameter int MAX_LEN = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start_dist,
  input  logic [12:0] im_base_addr,
  output logic        o_done_dist,
  output logic        o_error_dist,
  output logic [1:0]  om_err_code,
  output logic [12:0] om_cddb_addr,
  input  logic [7:0]  im_cddb_rdata,
  output logic        o_ch1_wren,
  output logic        o_ch2_wren,
  output logic        o_ch3_wren,
  output logic        o_ch4_wren,
  output logic        o_ch5_wren,
  output logic        o_ch6_wren,
  output logic [12:0] om_ch_addr,
  output logic [7:0]  om_ch_wdata,
  output logic        o_busy,
  output logic [2:0]  o_dbg_state
);

  // Handshake: i_start_dist is a one-cycle request accepted only in IDLE;
  // o_done_dist is a one-cycle response, o_error_dist qualifies it.
  typedef enum logic [2:0] {
    S_IDLE, S_RD_HDR, S_CHK_HDR, S_COPY, S_RD_SUM, S_COMMIT, S_DONE, S_ERR
  } state_t;

  localparam logic [16:0] LP_MAX_LEN = 17'(MAX_LEN);

  state_t      r_state, w_next;
  logic [12:0] r_base;
  logic [15:0] r_cnt;
  logic [7:0]  r_ch;
  logic [7:0]  r_len_hi;
  logic [15:0] r_len;
  logic [7:0]  r_sum;
  logic [1:0]  r_err_code;

  logic [15:0] w_len;
  logic [1:0]  w_hdr_code;
  logic        w_wr;
  logic        w_sum_ok;

  // The low length byte is checked straight off the read bus, saving a cycle.
  assign w_len    = {r_len_hi, im_cddb_rdata};
  assign w_sum_ok = (im_cddb_rdata == r_sum);

  always_comb begin
    w_hdr_code = 2'd0;
    if (r_ch == 8'd0 || r_ch > 8'd6)
      w_hdr_code = 2'd1;
    else if (w_len == 16'd0 || {1'b0, w_len} > LP_MAX_LEN)
      w_hdr_code = 2'd2;
  end

  always_comb begin
    w_next       = r_state;
    w_wr         = 1'b0;
    om_cddb_addr = 13'd0;
    om_ch_addr   = 13'd0;
    om_ch_wdata  = 8'd0;
    o_done_dist  = 1'b0;
    o_error_dist = 1'b0;
    case (r_state)
      S_IDLE: if (i_start_dist) w_next = S_RD_HDR;
      S_RD_HDR: begin
        om_cddb_addr = r_base + r_cnt[12:0];
        if (r_cnt == 16'd2) w_next = S_CHK_HDR;
      end
      S_CHK_HDR: w_next = (w_hdr_code != 2'd0) ? S_ERR : S_COPY;
      S_COPY: begin
        // Count LEN+1 cycles: read i while writing byte i-1; the final read is the checksum.
        om_cddb_addr = r_base + r_cnt[12:0] + 13'd3;
        if (r_cnt != 16'd0) begin
          w_wr        = 1'b1;
          om_ch_addr  = r_cnt[12:0] + 13'd1;
          om_ch_wdata = im_cddb_rdata;
        end
        if (r_cnt == r_len) w_next = S_RD_SUM;
      end
      S_RD_SUM: w_next = w_sum_ok ? S_COMMIT : S_ERR;
      S_COMMIT: begin
        w_wr        = 1'b1;
        om_ch_addr  = {12'd0, r_cnt[0]};
        om_ch_wdata = r_cnt[0] ? r_len[7:0] : r_len[15:8];
        if (r_cnt[0]) w_next = S_DONE;
      end
      S_DONE: begin
        o_done_dist = 1'b1;
        w_next      = S_IDLE;
      end
      S_ERR: begin
        o_done_dist  = 1'b1;
        o_error_dist = 1'b1;
        w_next       = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_base     <= 13'd0;
      r_cnt      <= 16'd0;
      r_ch       <= 8'd0;
      r_len_hi   <= 8'd0;
      r_len      <= 16'd0;
      r_sum      <= 8'd0;
      r_err_code <= 2'd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (i_start_dist) begin
          r_base     <= im_base_addr;
          r_err_code <= 2'd0;
          r_cnt      <= 16'd0;
          r_sum      <= 8'd0;
          r_len      <= 16'd0;
        end
        S_RD_HDR: begin
          r_cnt <= r_cnt + 16'd1;
          if (r_cnt == 16'd1) r_ch <= im_cddb_rdata;
          if (r_cnt == 16'd2) begin
            r_len_hi <= im_cddb_rdata;
            r_cnt    <= 16'd0;
          end
        end
        S_CHK_HDR: begin
          r_len <= w_len;
          r_cnt <= 16'd0;
          r_sum <= 8'd0;
          if (w_hdr_code != 2'd0) r_err_code <= w_hdr_code;
        end
        S_COPY: begin
          r_cnt <= (r_cnt == r_len) ? 16'd0 : r_cnt + 16'd1;
          if (r_cnt != 16'd0) r_sum <= r_sum + im_cddb_rdata;
        end
        S_RD_SUM: if (!w_sum_ok) r_err_code <= 2'd3;
        S_COMMIT: r_cnt <= r_cnt + 16'd1;
        default: ;
      endcase
    end
  end

  assign o_ch1_wren  = w_wr && (r_ch == 8'd1);
  assign o_ch2_wren  = w_wr && (r_ch == 8'd2);
  assign o_ch3_wren  = w_wr && (r_ch == 8'd3);
  assign o_ch4_wren  = w_wr && (r_ch == 8'd4);
  assign o_ch5_wren  = w_wr && (r_ch == 8'd5);
  assign o_ch6_wren  = w_wr && (r_ch == 8'd6);
  assign om_err_code = r_err_code;
  assign o_busy      = (r_state != S_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_datas_dist_cm.sv
// Scoreboard bench for datas_dist_cm: a CDDB memory model, frame driver tasks and
// a monitor that checks every channel write and done pulse against expected queues.
module tb_datas_dist_cm;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start_dist;
  logic [12:0] im_base_addr;
  logic        o_done_dist, o_error_dist;
  logic [1:0]  om_err_code;
  logic [12:0] om_cddb_addr;
  logic [7:0]  im_cddb_rdata;
  logic        o_ch1_wren, o_ch2_wren, o_ch3_wren, o_ch4_wren, o_ch5_wren, o_ch6_wren;
  logic [12:0] om_ch_addr;
  logic [7:0]  om_ch_wdata;
  logic        o_busy;
  logic [2:0]  o_dbg_state;

  datas_dist_cm #(.MAX_LEN(1024)) dut (
    .clk(clk), .rst(rst), .i_start_dist(i_start_dist), .im_base_addr(im_base_addr),
    .o_done_dist(o_done_dist), .o_error_dist(o_error_dist), .om_err_code(om_err_code),
    .om_cddb_addr(om_cddb_addr), .im_cddb_rdata(im_cddb_rdata),
    .o_ch1_wren(o_ch1_wren), .o_ch2_wren(o_ch2_wren), .o_ch3_wren(o_ch3_wren),
    .o_ch4_wren(o_ch4_wren), .o_ch5_wren(o_ch5_wren), .o_ch6_wren(o_ch6_wren),
    .om_ch_addr(om_ch_addr), .om_ch_wdata(om_ch_wdata), .o_busy(o_busy),
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // CDDB model: data returned one cycle after the address
  logic [7:0] mem [0:8191];
  always @(posedge clk) im_cddb_rdata <= mem[om_cddb_addr];

  // scoreboard: writes {ch[2:0], addr[12:0], data[7:0]}; dones {mode[1:0], lat[15:0], err, code[1:0]}
  logic [23:0] exp_q[$];
  logic [20:0] exp_done_q[$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int t0 = 0;
  logic [1:0] last_code = 2'd0;

  logic [5:0] wr_vec;
  assign wr_vec = {o_ch6_wren, o_ch5_wren, o_ch4_wren, o_ch3_wren, o_ch2_wren, o_ch1_wren};

  always @(negedge clk) begin
    logic [23:0] e, act;
    logic [20:0] d;
    logic [2:0]  ach;
    int          n, lat;
    if (rst) begin
      n = 0; ach = 3'd0;
      for (int k = 0; k < 6; k++) if (wr_vec[k]) begin n++; ach = 3'(k + 1); end
      checks++;
      if (n > 1) begin errors++; $display("FAIL wren_onehot act=%b req=one-hot", wr_vec); end
      if (n == 1) begin
        act = {ach, om_ch_addr, om_ch_wdata};
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL unexpected_write act=ch%0d a=%0d d=%h req=none", ach, om_ch_addr, om_ch_wdata);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            errors++;
            $display("FAIL chan_write act=ch%0d a=%0d d=%h req=ch%0d a=%0d d=%h",
                     act[23:21], act[20:8], act[7:0], e[23:21], e[20:8], e[7:0]);
          end
        end
      end else begin
        checks++;
        if (om_ch_addr !== 13'd0 || om_ch_wdata !== 8'd0) begin
          errors++; $display("FAIL idle_bus act=a%0d d%h req=0", om_ch_addr, om_ch_wdata);
        end
      end
      if (o_error_dist && !o_done_dist) begin
        errors++; $display("FAIL error_without_done act=1 req=0");
      end
      if (o_done_dist) begin
        done_cnt++;
        lat = cyc - t0;
        checks++;
        if (exp_done_q.size() == 0) begin
          errors++; $display("FAIL unexpected_done act=1 req=0");
        end else begin
          d = exp_done_q.pop_front();
          last_code = d[1:0];
          if (o_error_dist !== d[2] || om_err_code !== d[1:0]) begin
            errors++; $display("FAIL done_status act=err%0d code%0d req=err%0d code%0d",
                               o_error_dist, om_err_code, d[2], d[1:0]);
          end
          if (d[20:19] == 2'd1 && lat != int'(d[18:3])) begin
            errors++; $display("FAIL latency_exact act=%0d req=%0d", lat, d[18:3]);
          end
          if (d[20:19] == 2'd2 && lat > int'(d[18:3])) begin
            errors++; $display("FAIL latency_max act=%0d req<=%0d", lat, d[18:3]);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic check_zero(input string name);
    checks++;
    if ({o_done_dist, o_error_dist, om_err_code, om_cddb_addr, wr_vec, om_ch_addr, om_ch_wdata, o_busy} !== '0) begin
      errors++;
      $display("FAIL %s act=done%0d err%0d code%0d ra%0d wr%b wa%0d wd%h busy%0d req=all0", name,
               o_done_dist, o_error_dist, om_err_code, om_cddb_addr, wr_vec, om_ch_addr, om_ch_wdata, o_busy);
    end
  endtask

  task automatic pulse_start(input logic [12:0] base);
    @(posedge clk); #2;
    i_start_dist = 1'b1;
    im_base_addr = base;
    t0 = cyc;
    @(posedge clk); #2;
    i_start_dist = 1'b0;
    im_base_addr = 13'd0;
  endtask

  task automatic wait_done(input int budget);
    int  c0;
    bit  seen;
    c0 = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_cnt != c0) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL done_timeout act=none req=done within %0d cycles", budget);
    end
  endtask

  // reference model: derives expected writes/dones from the frame rules
  task automatic run_frame(input logic [12:0] base, input logic [7:0] ch, input int len,
                           input bit directed, input bit bad_sum, input bit extra_start, input int abort_at);
    logic [15:0] l16;
    logic [7:0]  b;
    int          sum, code;
    l16 = 16'(len);
    mem[base]          = ch;
    mem[base + 13'd1]  = l16[15:8];
    mem[base + 13'd2]  = l16[7:0];
    code = (ch < 8'd1 || ch > 8'd6) ? 1 : ((len == 0 || len > 1024) ? 2 : 0);
    sum = 0;
    if (code == 0) begin
      for (int i = 0; i < len; i++) begin
        b = directed ? 8'((i + 1) * 8'h11) : 8'($urandom_range(0, 255));
        mem[base + 13'(3 + i)] = b;
        sum = (sum + int'(b)) % 256;
        exp_q.push_back({ch[2:0], 13'(2 + i), b});
      end
      mem[base + 13'(3 + len)] = 8'((sum + (bad_sum ? 1 : 0)) % 256);
      if (bad_sum) exp_done_q.push_back({2'd0, 16'd0, 1'b1, 2'd3});
      else begin
        exp_q.push_back({ch[2:0], 13'd0, l16[15:8]});
        exp_q.push_back({ch[2:0], 13'd1, l16[7:0]});
        exp_done_q.push_back({2'd1, 16'(len + 9), 1'b0, 2'd0});
      end
    end else begin
      exp_done_q.push_back({2'd2, 16'd6, 1'b1, 2'(code)});
    end
    pulse_start(base);
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b1) begin errors++; $display("FAIL busy_after_start act=%0d req=1", o_busy); end
    if (abort_at > 0) begin
      repeat (abort_at) @(posedge clk);
      #2 rst = 1'b0;
      exp_q.delete();
      exp_done_q.delete();
      @(posedge clk);
      @(negedge clk);
      check_zero("abort_outputs_zero");
      @(posedge clk); #2 rst = 1'b1;
      repeat (20) @(posedge clk);
      return;
    end
    if (extra_start) begin
      repeat (6) @(posedge clk);
      #2 i_start_dist = 1'b1; im_base_addr = 13'h0AAA;
      @(posedge clk); #2 i_start_dist = 1'b0; im_base_addr = 13'd0;
    end
    wait_done(len + 40);
    @(negedge clk);
    checks++;
    if (om_err_code !== last_code) begin
      errors++; $display("FAIL code_held act=%0d req=%0d", om_err_code, last_code);
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom_range(0, 255));
    rst = 1'b0; i_start_dist = 1'b0; im_base_addr = 13'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset_outputs");
    @(posedge clk); #2 rst = 1'b1;
    repeat (2) @(posedge clk);

    run_frame(13'h0100, 8'd3, 4,    1'b1, 1'b0, 1'b0, 0);  // directed frame
    run_frame(13'h0200, 8'd7, 4,    1'b0, 1'b0, 1'b0, 0);  // bad channel
    run_frame(13'h0300, 8'd0, 4,    1'b0, 1'b0, 1'b0, 0);
    run_frame(13'h0400, 8'd2, 0,    1'b0, 1'b0, 1'b0, 0);  // bad lengths
    run_frame(13'h0500, 8'd2, 1025, 1'b0, 1'b0, 1'b0, 0);
    run_frame(13'h0600, 8'd4, 1024, 1'b0, 1'b0, 1'b0, 0);  // max length
    run_frame(13'h0100, 8'd3, 4,    1'b1, 1'b1, 1'b0, 0);  // wrong checksum
    run_frame(13'h1FFE, 8'd1, 2,    1'b0, 1'b0, 1'b0, 0);  // address wrap
    run_frame(13'h0800, 8'd5, 20,   1'b0, 1'b0, 1'b1, 0);  // start during COPY
    for (int k = 0; k < 8; k++)
      run_frame(13'($urandom_range(0, 8191)), 8'($urandom_range(1, 6)), $urandom_range(1, 40),
                1'b0, ($urandom_range(0, 3) == 0), 1'b0, 0);
    run_frame(13'h0A00, 8'd2, 16,   1'b0, 1'b0, 1'b0, 10); // reset mid-COPY
    run_frame(13'h0C00, 8'd6, 12,   1'b0, 1'b0, 1'b0, 0);  // runs normally afterwards

    checks++;
    if (exp_q.size() != 0 || exp_done_q.size() != 0) begin
      errors++; $display("FAIL leftover_expected act=%0d/%0d req=0/0", exp_q.size(), exp_done_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
